// File: rtl/axi4lite_regfile_pkg.sv
// Shared types and address decode for the AXI4-Lite register bank.
// Optional AxPROT privilege check is enabled with AXI4LITE_REGFILE_PROT_EN.
package axi4lite_regfile_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef logic [0:0] wr_state_t;
  localparam wr_state_t WR_IDLE = 1'b0;
  localparam wr_state_t WR_RESP = 1'b1;

  typedef logic [0:0] rd_state_t;
  localparam rd_state_t RD_IDLE = 1'b0;
  localparam rd_state_t RD_DATA = 1'b1;

  function automatic logic addr_hit(input logic [63:0] addr,
                                    input logic [63:0] base,
                                    input logic [63:0] span);
    return (addr >= base) && (addr < base + span);
  endfunction

endpackage

// File: rtl/axi4lite_regfile_if.sv
// AXI4-Lite bus bundle with master and slave views.
interface axi4lite_regfile_if #(
  parameter int N      = 4,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] AWADDR;
  logic [2:0]        AWPROT;
  logic              AWVALID;
  logic              AWREADY;
  logic [8*N-1:0]    WDATA;
  logic [N-1:0]      WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [2:0]        ARPROT;
  logic              ARVALID;
  logic              ARREADY;
  logic [8*N-1:0]    RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWPROT, AWVALID, WDATA, WSTRB, WVALID, BREADY,
           ARADDR, ARPROT, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4lite_regfile.sv
// AXI4-Lite register bank: NUM_REGS registers from BASE_ADDR, exposed to fabric.
// Define AXI4LITE_REGFILE_PROT_EN to reject unprivileged (AxPROT[0]==0) accesses.
//
//  state   | meaning
//  WR_IDLE | collecting AW and W independently; commits once both are held
//  WR_RESP | BVALID asserted, waiting for BREADY
//  RD_IDLE | ARREADY high, sampling register on AR handshake
//  RD_DATA | RVALID asserted, waiting for RREADY
module axi4lite_regfile
  import axi4lite_regfile_pkg::*;
#(
  parameter int              N         = 4,
  parameter int              ADDR_W    = 32,
  parameter int              NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h100
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  axi4lite_regfile_if.slave         s_axi,
  output logic [NUM_REGS*8*N-1:0]   regs_o,
  output logic [NUM_REGS-1:0]       wr_pulse
);

  localparam int DW    = 8 * N;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int OFS_W = $clog2(N);
  localparam logic [63:0] SPAN = 64'(NUM_REGS * N);

  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];
  wr_state_t           wr_state_q, wr_state_d;
  rd_state_t           rd_state_q, rd_state_d;
  logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic                awpriv_q, awpriv_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [N-1:0]        wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  resp_t               bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;

  logic [ADDR_W-1:0]   wr_ofs, rd_ofs;
  logic [IDX_W-1:0]    wr_idx, rd_idx;
  logic                wr_ok, rd_ok, awready, wready, arready;

  assign wr_ofs = awaddr_q - BASE_ADDR;
  assign rd_ofs = s_axi.ARADDR - BASE_ADDR;
  assign wr_idx = wr_ofs[OFS_W +: IDX_W];
  assign rd_idx = rd_ofs[OFS_W +: IDX_W];

`ifdef AXI4LITE_REGFILE_PROT_EN
  assign wr_ok = addr_hit(64'(awaddr_q), 64'(BASE_ADDR), SPAN) && awpriv_q;
  assign rd_ok = addr_hit(64'(s_axi.ARADDR), 64'(BASE_ADDR), SPAN) && s_axi.ARPROT[0];
`else
  assign wr_ok = addr_hit(64'(awaddr_q), 64'(BASE_ADDR), SPAN);
  assign rd_ok = addr_hit(64'(s_axi.ARADDR), 64'(BASE_ADDR), SPAN);
`endif

  // Only the index bits of the offsets and AxPROT[0] carry meaning.
  logic unused_bits;
  assign unused_bits = ^{wr_ofs, rd_ofs, s_axi.AWPROT, s_axi.ARPROT, awpriv_q};

  assign awready = (wr_state_q == WR_IDLE) && !aw_held_q;
  assign wready  = (wr_state_q == WR_IDLE) && !w_held_q;
  assign arready = (rd_state_q == RD_IDLE);

  always_comb begin
    regs_d     = regs_q;
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    awpriv_d   = awpriv_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    wr_pulse_d = '0;
    case (wr_state_q)
      WR_IDLE: begin
        if (s_axi.AWVALID && awready) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_axi.AWADDR;
          awpriv_d  = s_axi.AWPROT[0];
        end
        if (s_axi.WVALID && wready) begin
          w_held_d = 1'b1;
          wdata_d  = s_axi.WDATA;
          wstrb_d  = s_axi.WSTRB;
        end
        if (aw_held_q && w_held_q) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          bvalid_d   = 1'b1;
          wr_state_d = WR_RESP;
          if (wr_ok) begin
            bresp_d            = OKAY;
            wr_pulse_d[wr_idx] = 1'b1;
            for (int i = 0; i < N; i++)
              if (wstrb_q[i]) regs_d[wr_idx][8*i +: 8] = wdata_q[8*i +: 8];
          end else begin
            bresp_d = SLVERR;
          end
        end
      end
      default: begin
        if (s_axi.BREADY) begin
          bvalid_d   = 1'b0;
          wr_state_d = WR_IDLE;
        end
      end
    endcase
  end

  // Reads sample regs_q, so a same-edge commit is not visible yet.
  always_comb begin
    rd_state_d = rd_state_q;
    rvalid_d   = rvalid_q;
    rresp_d    = rresp_q;
    rdata_d    = rdata_q;
    case (rd_state_q)
      RD_IDLE: begin
        if (s_axi.ARVALID) begin
          rvalid_d   = 1'b1;
          rd_state_d = RD_DATA;
          rresp_d    = rd_ok ? OKAY : SLVERR;
          rdata_d    = rd_ok ? regs_q[rd_idx] : '0;
        end
      end
      default: begin
        if (s_axi.RREADY) begin
          rvalid_d   = 1'b0;
          rd_state_d = RD_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      regs_q     <= '{default: '0};
      wr_state_q <= WR_IDLE;
      rd_state_q <= RD_IDLE;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      awpriv_q   <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= OKAY;
      rvalid_q   <= 1'b0;
      rresp_q    <= OKAY;
      rdata_q    <= '0;
      wr_pulse_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      awpriv_q   <= awpriv_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rvalid_q   <= rvalid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
      wr_pulse_q <= wr_pulse_d;
    end
  end

  always_comb begin
    regs_o = '0;
    for (int k = 0; k < NUM_REGS; k++) regs_o[k*DW +: DW] = regs_q[k];
  end

  assign s_axi.AWREADY = awready;
  assign s_axi.WREADY  = wready;
  assign s_axi.ARREADY = arready;
  assign s_axi.BVALID  = bvalid_q;
  assign s_axi.BRESP   = bresp_q;
  assign s_axi.RVALID  = rvalid_q;
  assign s_axi.RRESP   = rresp_q;
  assign s_axi.RDATA   = rdata_q;
  assign wr_pulse      = wr_pulse_q;

endmodule

// File: tb/tb_axi4lite_regfile.sv
// Directed bench for axi4lite_regfile (default build or AXI4LITE_REGFILE_PROT_EN).
module tb_axi4lite_regfile;

  logic         ACLK = 1'b0;
  logic         ARESETn = 1'b0;
  logic [511:0] regs_o;
  logic [15:0]  wr_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt [16] = '{default: 0};
  int snap [16];
  logic [31:0] exp_regs [16] = '{default: 32'h0};
  logic [1:0]  resp;
  logic [31:0] rdata;

  axi4lite_regfile_if #(.N(4), .ADDR_W(32)) bus ();

  axi4lite_regfile #(.N(4), .ADDR_W(32), .NUM_REGS(16), .BASE_ADDR(32'h100)) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .s_axi    (bus),
    .regs_o   (regs_o),
    .wr_pulse (wr_pulse)
  );

  always #5 ACLK = ~ACLK;

  always @(negedge ACLK)
    for (int k = 0; k < 16; k++) if (wr_pulse[k]) pulse_cnt[k]++;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] exp_flat();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = exp_regs[k];
    return r;
  endfunction

  function automatic int pulse_delta(input int k);
    return pulse_cnt[k] - snap[k];
  endfunction

  function automatic int pulse_total();
    int t = 0;
    for (int k = 0; k < 16; k++) t += pulse_cnt[k] - snap[k];
    return t;
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] prot,
                           output logic [1:0] r);
    bit aw_ok, w_ok;
    int n;
    bus.AWADDR = addr; bus.AWPROT = prot; bus.AWVALID = 1'b1;
    bus.WDATA = data;  bus.WSTRB = strb;  bus.WVALID = 1'b1;
    n = 0;
    while ((bus.AWVALID || bus.WVALID) && n < 20) begin
      aw_ok = bus.AWREADY;
      w_ok  = bus.WREADY;
      tick();
      n++;
      if (aw_ok) bus.AWVALID = 1'b0;
      if (w_ok)  bus.WVALID = 1'b0;
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    n = 0;
    while (!bus.BVALID && n < 20) begin tick(); n++; end
    chk("wr_bvalid_seen", {511'b0, bus.BVALID}, 512'd1);
    r = bus.BRESP;
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [2:0] prot,
                          output logic [31:0] d, output logic [1:0] r);
    bit ok;
    int n;
    bus.ARADDR = addr; bus.ARPROT = prot; bus.ARVALID = 1'b1;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 20) begin
      ok = bus.ARREADY;
      tick();
      n++;
    end
    bus.ARVALID = 1'b0;
    n = 0;
    while (!bus.RVALID && n < 20) begin tick(); n++; end
    chk("rd_rvalid_seen", {511'b0, bus.RVALID}, 512'd1);
    d = bus.RDATA;
    r = bus.RRESP;
    bus.RREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0;
  endtask

  initial begin
    bus.AWADDR = '0; bus.AWPROT = 3'b001; bus.AWVALID = 1'b0;
    bus.WDATA = '0;  bus.WSTRB = '0;      bus.WVALID = 1'b0;
    bus.BREADY = 1'b0;
    bus.ARADDR = '0; bus.ARPROT = 3'b001; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;
    snap = pulse_cnt;

    // Reset values
    tick(); tick();
    chk("rst_awready", {511'b0, bus.AWREADY}, 512'd1);
    chk("rst_wready",  {511'b0, bus.WREADY},  512'd1);
    chk("rst_arready", {511'b0, bus.ARREADY}, 512'd1);
    chk("rst_bvalid",  {511'b0, bus.BVALID},  512'd0);
    chk("rst_rvalid",  {511'b0, bus.RVALID},  512'd0);
    chk("rst_bresp",   {510'b0, bus.BRESP},   512'd0);
    chk("rst_rresp",   {510'b0, bus.RRESP},   512'd0);
    chk("rst_rdata",   {480'b0, bus.RDATA},   512'd0);
    chk("rst_pulse",   {496'b0, wr_pulse},    512'd0);
    chk("rst_regs",    regs_o,                512'd0);
    ARESETn = 1'b1;
    tick();
    chk("post_rst_awready", {511'b0, bus.AWREADY}, 512'd1);

    // 1: partial-strobe write to reg0
    snap = pulse_cnt;
    axi_write(32'h100, 32'h12345678, 4'b1011, 3'b001, resp);
    exp_regs[0] = 32'h12005678;
    chk("t1_bresp", {510'b0, resp}, 512'd0);
    chk("t1_reg0",  {480'b0, regs_o[31:0]}, {480'b0, 32'h12005678});
    chk("t1_pulse0", 512'(pulse_delta(0)), 512'd1);
    chk("t1_pulse_total", 512'(pulse_total()), 512'd1);

    // 2: out-of-range write
    snap = pulse_cnt;
    axi_write(32'h12345678, 32'h0000ABCD, 4'hF, 3'b001, resp);
    chk("t2_bresp", {510'b0, resp}, 512'd2);
    chk("t2_regs", regs_o, exp_flat());
    chk("t2_pulse_total", 512'(pulse_total()), 512'd0);

    // 3: reads in range, unaligned, and out of range
    axi_read(32'h100, 3'b001, rdata, resp);
    chk("t3_rdata0", {480'b0, rdata}, {480'b0, 32'h12005678});
    chk("t3_rresp0", {510'b0, resp}, 512'd0);
    axi_read(32'h102, 3'b001, rdata, resp);
    chk("t3_rdata_unaligned", {480'b0, rdata}, {480'b0, 32'h12005678});
    axi_read(32'h20, 3'b001, rdata, resp);
    chk("t3_rdata_oor", {480'b0, rdata}, 512'd0);
    chk("t3_rresp_oor", {510'b0, resp}, 512'd2);

    // 4: W three cycles ahead of AW, BREADY held low
    snap = pulse_cnt;
    bus.WDATA = 32'hCAFEF00D; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.WVALID = 1'b0;
    chk("t4_wready_low", {511'b0, bus.WREADY}, 512'd0);
    chk("t4_awready_high", {511'b0, bus.AWREADY}, 512'd1);
    tick(); tick();
    bus.AWADDR = 32'h108; bus.AWPROT = 3'b001; bus.AWVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0;
    chk("t4_bvalid_not_yet", {511'b0, bus.BVALID}, 512'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("t4_bvalid_held",  {511'b0, bus.BVALID},  512'd1);
      chk("t4_bresp_held",   {510'b0, bus.BRESP},   512'd0);
      chk("t4_awready_low",  {511'b0, bus.AWREADY}, 512'd0);
      chk("t4_wready_low2",  {511'b0, bus.WREADY},  512'd0);
      tick();
    end
    bus.BREADY = 1'b1;
    tick();
    bus.BREADY = 1'b0;
    exp_regs[2] = 32'hCAFEF00D;
    chk("t4_bvalid_done", {511'b0, bus.BVALID}, 512'd0);
    chk("t4_awready_back", {511'b0, bus.AWREADY}, 512'd1);
    chk("t4_wready_back", {511'b0, bus.WREADY}, 512'd1);
    chk("t4_pulse2", 512'(pulse_delta(2)), 512'd1);
    chk("t4_pulse_total", 512'(pulse_total()), 512'd1);
    chk("t4_regs", regs_o, exp_flat());

    // 5: read of reg3 sampled on the same edge its write commits
    bus.AWADDR = 32'h10C; bus.AWVALID = 1'b1;
    bus.WDATA = 32'hFFFFFFFF; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    bus.ARADDR = 32'h10C; bus.ARPROT = 3'b001; bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    chk("t5_rvalid", {511'b0, bus.RVALID}, 512'd1);
    chk("t5_rdata_old", {480'b0, bus.RDATA}, 512'd0);
    chk("t5_bvalid", {511'b0, bus.BVALID}, 512'd1);
    chk("t5_pulse3", {511'b0, wr_pulse[3]}, 512'd1);
    bus.RREADY = 1'b1; bus.BREADY = 1'b1;
    tick();
    bus.RREADY = 1'b0; bus.BREADY = 1'b0;
    exp_regs[3] = 32'hFFFFFFFF;
    axi_read(32'h10C, 3'b001, rdata, resp);
    chk("t5_rdata_new", {480'b0, rdata}, {480'b0, 32'hFFFFFFFF});

    // Range boundaries: last register and first address past it
    axi_write(32'h13C, 32'hA5A5A5A5, 4'hF, 3'b001, resp);
    exp_regs[15] = 32'hA5A5A5A5;
    chk("bnd_last_bresp", {510'b0, resp}, 512'd0);
    chk("bnd_regs", regs_o, exp_flat());
    axi_read(32'h140, 3'b001, rdata, resp);
    chk("bnd_past_rresp", {510'b0, resp}, 512'd2);
    axi_read(32'hFC, 3'b001, rdata, resp);
    chk("bnd_below_rresp", {510'b0, resp}, 512'd2);
    chk("bnd_below_rdata", {480'b0, rdata}, 512'd0);

    // 6: reset while BVALID is pending
    bus.AWADDR = 32'h104; bus.AWVALID = 1'b1;
    bus.WDATA = 32'h00000055; bus.WSTRB = 4'hF; bus.WVALID = 1'b1;
    tick();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    tick();
    chk("t6_bvalid_pre", {511'b0, bus.BVALID}, 512'd1);
    ARESETn = 1'b0;
    #1;
    chk("t6_bvalid_async", {511'b0, bus.BVALID}, 512'd0);
    chk("t6_regs_zero", regs_o, 512'd0);
    chk("t6_pulse_zero", {496'b0, wr_pulse}, 512'd0);
    for (int k = 0; k < 16; k++) exp_regs[k] = 32'h0;
    tick();
    ARESETn = 1'b1;
    tick();
    chk("t6_awready", {511'b0, bus.AWREADY}, 512'd1);
    chk("t6_wready",  {511'b0, bus.WREADY},  512'd1);
    chk("t6_arready", {511'b0, bus.ARREADY}, 512'd1);
    chk("t6_bvalid",  {511'b0, bus.BVALID},  512'd0);

    // Unprivileged access
    snap = pulse_cnt;
    axi_write(32'h108, 32'h11111111, 4'hF, 3'b000, resp);
`ifdef AXI4LITE_REGFILE_PROT_EN
    chk("prot_bresp", {510'b0, resp}, 512'd2);
    chk("prot_pulse_total", 512'(pulse_total()), 512'd0);
`else
    exp_regs[2] = 32'h11111111;
    chk("prot_bresp", {510'b0, resp}, 512'd0);
    chk("prot_pulse_total", 512'(pulse_total()), 512'd1);
`endif
    chk("prot_regs", regs_o, exp_flat());
    axi_read(32'h108, 3'b000, rdata, resp);
`ifdef AXI4LITE_REGFILE_PROT_EN
    chk("prot_rresp", {510'b0, resp}, 512'd2);
    chk("prot_rdata", {480'b0, rdata}, 512'd0);
`else
    chk("prot_rresp", {510'b0, resp}, 512'd0);
    chk("prot_rdata", {480'b0, rdata}, {480'b0, 32'h11111111});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
